dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported data cache between the two memory-stage lanes of the dual-issue pipeline and sequences miss handling (dirty-victim writeback, line refill, retry) against main memory. Lane 0 is always the older instruction and is served first. The block sits between the two EX/MEM registers and the data cache. It drives the memory-stage stall that freezes EX/MEM and all earlier stages.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- LINE_WORDS, 4, words per cache line (power of 2, ≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- memread_m_0 / memread_m_1  in  1  load request, lane 0 / lane 1
- memwrite_m_0 / memwrite_m_1  in  1  store request, lane 0 / lane 1
- addr_m_0 / addr_m_1  in  ADDR_WIDTH  word-aligned access address
- wdata_m_0 / wdata_m_1  in  DATA_WIDTH  store data
- readdata_m_0 / readdata_m_1  out  DATA_WIDTH  load result, valid when stall_mem=0
- stall_mem  out  1  freeze memory stage and upstream
- c_addr  out  ADDR_WIDTH  cache access address
- c_re, c_we  out  1  cache read / write strobe
- c_wdata  out  DATA_WIDTH  cache write data (store or refill word)
- c_fill  out  1  refill-word write (sets valid, clears dirty on last beat)
- c_rdata  in  DATA_WIDTH  cache read data, combinational on c_addr
- c_hit  in  1  combinational hit for c_addr
- c_valid_dirty  in  1  victim line at c_addr index is valid and dirty
- c_victim_addr  in  ADDR_WIDTH  line base address of the victim
- mem_req, mem_we  out  1  main-memory beat request / write
- mem_addr  out  ADDR_WIDTH  beat address
- mem_wdata  out  DATA_WIDTH  writeback word, taken from c_rdata
- mem_rdata  in  DATA_WIDTH  refill word
- mem_ready  in  1  beat accepted/completed this cycle

## Operation
- States: IDLE, LANE1, WB, FILL, RETRY.
- Current lane:
  - Lane 0 if it has a request and is not yet done.
  - Otherwise lane 1.
  - "Request" means memread or memwrite.
- IDLE: drives the current lane's access to the cache.
  - Hit, no other request pending: the access completes, stall_mem=0, and the state stays IDLE.
  - Hit by lane 0 while lane 1 also requests: capture lane 0's data, set done0, stall_mem=1, go to LANE1.
  - Miss with c_valid_dirty=1: go to WB.
  - Miss with c_valid_dirty=0: go to FILL.
  - A miss asserts stall_mem=1.
- LANE1: lane 1 access. Hit: stall_mem=0, clear done0, go to IDLE. Miss: go to WB or FILL as in IDLE.
- WB: LINE_WORDS beats.
  - mem_we=1, mem_addr = c_victim_addr + 4·beat.
  - c_addr points at the victim word, c_re=1, mem_wdata=c_rdata.
  - The beat counter advances on mem_ready. After the last beat, go to FILL.
- FILL: LINE_WORDS beats.
  - mem_addr = line base of the miss address + 4·beat.
  - On mem_ready, write mem_rdata to the cache with c_fill=1.
  - After the last beat, go to RETRY.
- RETRY: reissue the missed access. It is a guaranteed hit.
  - If it was lane 0 and lane 1 is still pending: capture, set done0, go to LANE1.
  - Otherwise: stall_mem=0, clear done0, go to IDLE.
- Stores write c_wdata=wdata at c_addr with c_we=1, only on a hit or in RETRY. A store never writes on a miss.
- readdata_m_0 = captured register when done0, else c_rdata. readdata_m_1 = c_rdata.
- Same-address accesses from both lanes resolve in program order: lane 0 first.
- A lane with no request is skipped and never stalls.
- Beat counter is log2(LINE_WORDS) bits. It wraps to 0 on each WB→FILL and FILL→RETRY transition.

## Timing
- Reset values:
  - State IDLE, beat counter 0, done0=0, captured data 0.
  - mem_req=0, mem_we=0, c_re=0, c_we=0, c_fill=0.
  - stall_mem=0, all address/data outputs 0.
- Single-lane hit: 0 stall cycles.
- Both lanes hit: exactly 1 stall cycle.
- Clean miss: 1 + Σ(FILL beat cycles) stall cycles. stall_mem falls in the RETRY cycle.
- Dirty miss: adds Σ(WB beat cycles).
- mem_req is asserted in every WB/FILL cycle. mem_addr, mem_we and mem_wdata stay stable until mem_ready. Back-to-back beats are allowed.
- stall_mem is combinational from the state and c_hit. The EX/MEM inputs are held constant by the stall itself.
- Asynchronous reset in any state:
  - Return to IDLE and drop mem_req the same instant.
  - Abandon a partial refill. The cache line is left invalid, because c_fill never completed the last beat.

## Test plan
- Lane 0 load hit to 0x100 (c_rdata=0xDEADBEEF), lane 1 idle -> stall_mem=0 throughout; readdata_m_0=0xDEADBEEF the same cycle.
- Lane 0 load 0x100 (0x11111111) and lane 1 load 0x200 (0x22222222), both hit -> stall_mem=1 for 1 cycle; next cycle readdata_m_0=0x11111111, readdata_m_1=0x22222222, stall_mem=0.
- Lane 1 load miss, clean, mem_ready every cycle, LINE_WORDS=4 -> mem_addr 0x200,0x204,0x208,0x20C; 4 c_fill pulses; RETRY hit; stall_mem high for 5 cycles.
- Lane 0 store 0x300 (0xCAFE) missing a dirty victim at 0x700 -> 4 WB beats at 0x700–0x70C with mem_we=1, then 4 FILL beats at 0x300–0x30C, then c_we=1 with c_wdata=0xCAFE in RETRY.
- Lane 0 store 0x400 (0x5) and lane 1 load 0x400, both hit -> the store is written first; readdata_m_1=0x5 after 1 stall cycle.
- Assert reset during the 2nd FILL beat with mem_ready low -> mem_req=0 and stall_mem=0 immediately, state IDLE; the next hit access completes with 0 stall.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the memory-stage lanes, the data cache and the main-memory beat port.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  memread_m_0, memread_m_1;
  logic                  memwrite_m_0, memwrite_m_1;
  logic [ADDR_WIDTH-1:0] addr_m_0, addr_m_1;
  logic [DATA_WIDTH-1:0] wdata_m_0, wdata_m_1;
  logic [DATA_WIDTH-1:0] readdata_m_0, readdata_m_1;
  logic                  stall_mem;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  c_re, c_we, c_fill;
  logic [DATA_WIDTH-1:0] c_wdata, c_rdata;
  logic                  c_hit, c_valid_dirty;
  logic [ADDR_WIDTH-1:0] c_victim_addr;
  logic                  mem_req, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic                  mem_ready;
  logic [2:0]            dbg_state;

  // Memory beats: a beat transfers on every cycle with mem_req && mem_ready; mem_addr,
  // mem_we and mem_wdata hold steady while mem_req is high and mem_ready is low.
  modport master (
    output memread_m_0, memread_m_1, memwrite_m_0, memwrite_m_1,
    output addr_m_0, addr_m_1, wdata_m_0, wdata_m_1,
    output c_rdata, c_hit, c_valid_dirty, c_victim_addr, mem_rdata, mem_ready,
    input  readdata_m_0, readdata_m_1, stall_mem,
    input  c_addr, c_re, c_we, c_wdata, c_fill,
    input  mem_req, mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport slave (
    input  memread_m_0, memread_m_1, memwrite_m_0, memwrite_m_1,
    input  addr_m_0, addr_m_1, wdata_m_0, wdata_m_1,
    input  c_rdata, c_hit, c_valid_dirty, c_victim_addr, mem_rdata, mem_ready,
    output readdata_m_0, readdata_m_1, stall_mem,
    output c_addr, c_re, c_we, c_wdata, c_fill,
    output mem_req, mem_we, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data cache between two memory-stage lanes (lane 0 first) and
// sequences victim writeback, line refill and retry against main memory.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LANE1, S_WB, S_FILL, S_RETRY} state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  done0_q, done0_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;

  logic                  req0, req1, cur1, cur_rd, cur_wr;
  logic [ADDR_WIDTH-1:0] cur_addr, beat_off, line_base;
  logic [DATA_WIDTH-1:0] cur_wdata;
  state_e                miss_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      done0_q <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      done0_q <= done0_d;
      cap_q   <= cap_d;
    end
  end

  // Lane 0 is served until it is done; the EX/MEM inputs are frozen by our own stall.
  always_comb begin
    req0      = bus.memread_m_0 | bus.memwrite_m_0;
    req1      = bus.memread_m_1 | bus.memwrite_m_1;
    cur1      = !(req0 && !done0_q);
    cur_rd    = cur1 ? bus.memread_m_1  : bus.memread_m_0;
    cur_wr    = cur1 ? bus.memwrite_m_1 : bus.memwrite_m_0;
    cur_addr  = cur1 ? bus.addr_m_1     : bus.addr_m_0;
    cur_wdata = cur1 ? bus.wdata_m_1    : bus.wdata_m_0;
    beat_off  = ADDR_WIDTH'({beat_q, 2'b00});
    line_base = cur_addr & ~LINE_MASK;
    miss_next = bus.c_valid_dirty ? S_WB : S_FILL;
  end

  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    done0_d           = done0_q;
    cap_d             = cap_q;
    bus.stall_mem     = 1'b0;
    bus.c_addr        = '0;
    bus.c_re          = 1'b0;
    bus.c_we          = 1'b0;
    bus.c_wdata       = '0;
    bus.c_fill        = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.readdata_m_0  = '0;
    bus.readdata_m_1  = '0;
    bus.dbg_state     = state_q;

    // While reset is held every output sits at its idle value, whatever the lanes request.
    if (!reset) begin
      bus.readdata_m_0 = done0_q ? cap_q : bus.c_rdata;
      bus.readdata_m_1 = bus.c_rdata;
      case (state_q)
        S_IDLE, S_LANE1: begin
          if (cur_rd || cur_wr) begin
            bus.c_addr  = cur_addr;
            bus.c_re    = cur_rd;
            bus.c_wdata = cur_wdata;
            if (bus.c_hit) begin
              bus.c_we = cur_wr;
              if (!cur1 && req1) begin
                cap_d         = bus.c_rdata;
                done0_d       = 1'b1;
                bus.stall_mem = 1'b1;
                state_d       = S_LANE1;
              end else begin
                done0_d = 1'b0;
                state_d = S_IDLE;
              end
            end else begin
              bus.stall_mem = 1'b1;
              state_d       = miss_next;
            end
          end else begin
            done0_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_WB: begin
          bus.stall_mem = 1'b1;
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.c_victim_addr + beat_off;
          bus.c_addr    = bus.c_victim_addr + beat_off;
          bus.c_re      = 1'b1;
          bus.mem_wdata = bus.c_rdata;
          if (bus.mem_ready) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = S_FILL;
            end
          end
        end
        S_FILL: begin
          bus.stall_mem = 1'b1;
          bus.mem_req   = 1'b1;
          bus.mem_addr  = line_base + beat_off;
          bus.c_addr    = line_base + beat_off;
          bus.c_wdata   = bus.mem_rdata;
          if (bus.mem_ready) begin
            bus.c_we   = 1'b1;
            bus.c_fill = 1'b1;
            beat_d     = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = S_RETRY;
            end
          end
        end
        S_RETRY: begin
          // The line was just refilled, so the reissued access hits by construction.
          bus.c_addr  = cur_addr;
          bus.c_re    = cur_rd;
          bus.c_we    = cur_wr;
          bus.c_wdata = cur_wdata;
          if (!cur1 && req1) begin
            cap_d         = bus.c_rdata;
            done0_d       = 1'b1;
            bus.stall_mem = 1'b1;
            state_d       = S_LANE1;
          end else begin
            done0_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a memory/cache environment, a transaction-level model of
// program-order results, beat sequences and stall lengths, and a per-cycle compare process.
module tb_dmem_arbiter;
  localparam int LW = 4;
  localparam int W  = 65;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(LW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: cache data/valid, main memory, and the architectural (golden) word values.
  logic [31:0] cdata [1024];
  logic [31:0] mmem  [1024];
  logic [31:0] gold  [1024];
  logic        res   [256];
  logic        vic_dirty;
  logic [31:0] vic_base;
  int          gap;
  int          rdy_cnt;

  assign bus.c_rdata       = cdata[bus.c_addr[11:2]];
  assign bus.c_hit         = res[bus.c_addr[11:4]];
  assign bus.c_valid_dirty = vic_dirty && !res[bus.c_addr[11:4]];
  assign bus.c_victim_addr = vic_base;
  assign bus.mem_rdata     = mmem[bus.mem_addr[11:2]];
  assign bus.mem_ready     = bus.mem_req && (rdy_cnt == gap);

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [31:0]  beat_log[$];
  int           exp_stall;
  int           stall_cnt;
  int           last_stall;
  logic [31:0]  last_rd0, last_rd1;
  bit           txn_done;
  bit           mon_en;
  int           fill_seen;
  bit           held_v;
  logic [31:0]  held_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Synchronous cache/memory writes, applied just after the edge that performs them.
  initial begin
    logic        s_we, s_fill, s_hs, s_mwe, s_req;
    logic [31:0] s_caddr, s_cw, s_maddr, s_mw;
    forever begin
      @(negedge clk);
      s_we = bus.c_we;   s_fill = bus.c_fill; s_caddr = bus.c_addr; s_cw = bus.c_wdata;
      s_hs = bus.mem_req && bus.mem_ready; s_mwe = bus.mem_we; s_req = bus.mem_req;
      s_maddr = bus.mem_addr; s_mw = bus.mem_wdata;
      @(posedge clk);
      #1;
      if (s_we) cdata[s_caddr[11:2]] = s_cw;
      if (s_fill && s_caddr[3:2] == 2'b11) begin
        res[s_caddr[11:4]] = 1'b1;
        vic_dirty = 1'b0;
      end
      if (s_hs && s_mwe) mmem[s_maddr[11:2]] = s_mw;
      if (s_hs) rdy_cnt = 0;
      else if (s_req) rdy_cnt++;
    end
  end

  // Compare process: beats, stores, held beat fields, completion results and stall length.
  initial begin
    logic [W-1:0] e;
    bit           req_any;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.c_fill) fill_seen++;
        if (held_v && bus.mem_req) chk("mem_addr_held", bus.mem_addr, held_addr);
        held_v    = bus.mem_req && !bus.mem_ready;
        held_addr = bus.mem_addr;
        if (bus.mem_req && bus.mem_ready) begin
          beat_log.push_back(bus.mem_addr);
          if (exp_q.size() == 0) begin
            chk("mem_beat_unexpected", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("mem_addr", bus.mem_addr, e[63:32]);
            chk("mem_we", 32'(bus.mem_we), 32'(e[64]));
            if (e[64]) chk("mem_wdata", bus.mem_wdata, e[31:0]);
          end
        end
        if (bus.c_we && !bus.c_fill) begin
          chk("store_only_on_hit", 32'(bus.c_hit), 32'd1);
          chk("c_wdata", bus.c_wdata,
              (bus.memwrite_m_0 && bus.c_addr == bus.addr_m_0) ? bus.wdata_m_0 : bus.wdata_m_1);
        end
        req_any = bus.memread_m_0 | bus.memwrite_m_0 | bus.memread_m_1 | bus.memwrite_m_1;
        if (req_any && !txn_done) begin
          if (bus.stall_mem) begin
            stall_cnt++;
          end else begin
            if (bus.memread_m_0) chk("readdata_m_0", bus.readdata_m_0, gold[bus.addr_m_0[11:2]]);
            if (bus.memwrite_m_0) gold[bus.addr_m_0[11:2]] = bus.wdata_m_0;
            if (bus.memread_m_1) chk("readdata_m_1", bus.readdata_m_1, gold[bus.addr_m_1[11:2]]);
            if (bus.memwrite_m_1) gold[bus.addr_m_1[11:2]] = bus.wdata_m_1;
            chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
            chk("beats_left", 32'(exp_q.size()), 32'd0);
            last_rd0   = bus.readdata_m_0;
            last_rd1   = bus.readdata_m_1;
            last_stall = stall_cnt;
            stall_cnt  = 0;
            txn_done   = 1'b1;
          end
        end
      end
    end
  end

  // Model: a missing lane costs one lookup cycle, an optional writeback line and a refill line.
  function automatic int model_stall(bit q0, bit m0, bit q1, bit m1, bit dirty);
    int line_cyc = LW * (gap + 1);
    int s = (q0 && q1) ? 1 : 0;
    if (m0) s += 1 + line_cyc + (dirty ? line_cyc : 0);
    if (m1) s += 1 + line_cyc + (dirty ? line_cyc : 0);
    return s;
  endfunction

  task automatic push_miss(input logic [31:0] a, input bit dirty);
    logic [31:0] ad;
    if (dirty)
      for (int i = 0; i < LW; i++) begin
        ad = vic_base + 32'(4 * i);
        exp_q.push_back({1'b1, ad, gold[ad[11:2]]});
      end
    for (int i = 0; i < LW; i++) begin
      ad = (a & ~32'hF) + 32'(4 * i);
      exp_q.push_back({1'b0, ad, 32'h0});
    end
  endtask

  task automatic drive(input bit r0, w0, input logic [31:0] a0, d0,
                       input bit r1, w1, input logic [31:0] a1, d1);
    bus.memread_m_0 = r0; bus.memwrite_m_0 = w0; bus.addr_m_0 = a0; bus.wdata_m_0 = d0;
    bus.memread_m_1 = r1; bus.memwrite_m_1 = w1; bus.addr_m_1 = a1; bus.wdata_m_1 = d1;
  endtask

  task automatic issue(input bit r0, w0, input logic [31:0] a0, d0,
                       input bit r1, w1, input logic [31:0] a1, d1, input int lit_stall);
    bit q0, q1, m0, m1, dirty;
    @(posedge clk);
    #2;
    q0 = r0 | w0;
    q1 = r1 | w1;
    m0 = q0 && !res[a0[11:4]];
    m1 = q1 && !res[a1[11:4]];
    dirty = vic_dirty;
    beat_log.delete();
    if (m0) push_miss(a0, dirty);
    if (m1) push_miss(a1, dirty);
    exp_stall = model_stall(q0, m0, q1, m1, dirty);
    stall_cnt = 0;
    txn_done  = 1'b0;
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    repeat (300) begin
      @(negedge clk);
      #1;
      if (txn_done) break;
    end
    chk("txn_completed", 32'(txn_done), 32'd1);
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    txn_done = 1'b1;
    chk("stall_literal", 32'(last_stall), 32'(lit_stall));
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v, input bit in_c, input bit in_m);
    gold[a[11:2]] = v;
    if (in_c) cdata[a[11:2]] = v;
    if (in_m) mmem[a[11:2]] = v;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; mon_en = 1'b0; txn_done = 1'b1; held_v = 1'b0;
    vic_dirty = 1'b0; vic_base = 32'h0; gap = 0; rdy_cnt = 0;
    stall_cnt = 0; exp_stall = 0; last_stall = 0; fill_seen = 0;
    last_rd0 = '0; last_rd1 = '0; held_addr = '0;
    for (int i = 0; i < 1024; i++) begin cdata[i] = '0; mmem[i] = '0; gold[i] = '0; end
    for (int i = 0; i < 256; i++) res[i] = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(bus.stall_mem), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_c_re_we_fill", {29'd0, bus.c_re, bus.c_we, bus.c_fill}, 32'd0);
    chk("rst_c_addr", bus.c_addr, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;

    // Single-lane load hit
    set_word(32'h100, 32'hDEADBEEF, 1, 1); res[8'h10] = 1'b1;
    issue(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t1_rd0", last_rd0, 32'hDEADBEEF);

    // Lane 1 clean miss, ready every cycle
    for (int i = 0; i < LW; i++) set_word(32'h200 + 32'(4 * i), 32'h2000_0000 + 32'(i), 0, 1);
    issue(0, 0, 0, 0, 1, 0, 32'h200, 0, 5);
    chk("t3_rd1", last_rd1, 32'h2000_0000);
    chk("t3_beat0", beat_log[0], 32'h200);
    chk("t3_beat3", beat_log[3], 32'h20C);

    // Both lanes hit
    set_word(32'h100, 32'h11111111, 1, 1);
    set_word(32'h200, 32'h22222222, 1, 1);
    issue(1, 0, 32'h100, 0, 1, 0, 32'h200, 0, 1);
    chk("t2_rd0", last_rd0, 32'h11111111);
    chk("t2_rd1", last_rd1, 32'h22222222);

    // Lane 0 store miss with dirty victim
    for (int i = 0; i < LW; i++) begin
      set_word(32'h700 + 32'(4 * i), 32'h7000_0000 + 32'(i), 1, 0);
      set_word(32'h300 + 32'(4 * i), 32'h3000_0000 + 32'(i), 0, 1);
    end
    vic_dirty = 1'b1; vic_base = 32'h700;
    issue(0, 1, 32'h300, 32'hCAFE, 0, 0, 0, 0, 9);
    chk("t4_wb_beat0", beat_log[0], 32'h700);
    chk("t4_fill_beat0", beat_log[4], 32'h300);
    for (int i = 0; i < LW; i++) chk("t4_victim_written", mmem[9'h1C0 + 9'(i)], 32'h7000_0000 + 32'(i));
    chk("t4_store_data", cdata[32'h300 >> 2], 32'hCAFE);

    // Same-address store then load resolves in program order
    set_word(32'h400, 32'h0, 1, 1); res[8'h40] = 1'b1;
    issue(0, 1, 32'h400, 32'h5, 1, 0, 32'h400, 0, 1);
    chk("t5_rd1", last_rd1, 32'h5);

    // Lane 1 alone hits; lane 0 skipped
    issue(0, 0, 0, 0, 1, 0, 32'h400, 0, 0);
    chk("t5b_rd1", last_rd1, 32'h5);

    // Lane 0 clean miss with slow memory, lane 1 hit
    gap = 1;
    for (int i = 0; i < LW; i++) set_word(32'h500 + 32'(4 * i), 32'h5000_0000 + 32'(i), 0, 1);
    issue(1, 0, 32'h500, 0, 1, 0, 32'h100, 0, 10);
    chk("t6_rd0", last_rd0, 32'h5000_0000);
    chk("t6_rd1", last_rd1, 32'h11111111);

    // Lane 0 hit, lane 1 store miss with dirty victim
    gap = 0;
    for (int i = 0; i < LW; i++) begin
      set_word(32'h800 + 32'(4 * i), 32'h8000_0000 + 32'(i), 1, 0);
      set_word(32'h600 + 32'(4 * i), 32'h6000_0000 + 32'(i), 0, 1);
    end
    vic_dirty = 1'b1; vic_base = 32'h800;
    issue(1, 0, 32'h200, 0, 0, 1, 32'h600, 32'hBEEF, 10);
    chk("t7_rd0", last_rd0, 32'h22222222);
    chk("t7_victim_written", mmem[32'h80C >> 2], 32'h8000_0003);
    chk("t7_store_data", cdata[32'h600 >> 2], 32'hBEEF);

    // Reset during the second refill beat with mem_ready low
    gap = 1;
    for (int i = 0; i < LW; i++) set_word(32'h900 + 32'(4 * i), 32'h9000_0000 + 32'(i), 0, 1);
    @(posedge clk);
    #2;
    push_miss(32'h900, 0);
    fill_seen = 0; stall_cnt = 0; txn_done = 1'b0;
    drive(1, 0, 32'h900, 0, 0, 0, 0, 0);
    repeat (50) begin
      @(negedge clk);
      #1;
      if (fill_seen >= 1) break;
    end
    chk("t8_first_beat", 32'(fill_seen), 32'd1);
    @(posedge clk);
    #2;
    chk("t8_pre_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t8_pre_ready_low", 32'(bus.mem_ready), 32'd0);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("t8_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t8_stall", 32'(bus.stall_mem), 32'd0);
    chk("t8_state", 32'(bus.dbg_state), 32'd0);
    chk("t8_fill", 32'(bus.c_fill), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    stall_cnt = 0; txn_done = 1'b1; held_v = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("t8_line_invalid", 32'(res[8'h90]), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    gap = 0;
    issue(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t9_rd0", last_rd0, 32'h11111111);
    issue(1, 0, 32'h904, 0, 0, 0, 0, 0, 5);
    chk("t10_rd0", last_rd0, 32'h9000_0001);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
